rgb_pwm_fader: RTL and testbench
================================

// Module: rgb_pwm_fader
// PURPOSE
//  Three-channel PWM and fade generator that feeds the RGB0PWM/RGB1PWM/RGB2PWM inputs of SB_RGBA_DRV.
//  Control logic writes a target duty per channel through a valid/ready port.
//  Each channel's current duty then ramps one LSB at a time toward its target ("breathing").
//  Sits between the touch-pad/control logic and the LED driver hard IP in the top level.
// PARAMETERS
//  PWM_BITS  8    duty and PWM counter width; PWM period = 2**PWM_BITS ticks.
//  PRESCALE  188  clk cycles per PWM tick; 48 MHz/188/256 gives a PWM rate of about 1 kHz. Legal range >=1.
//  STEP_DIV  16   PWM periods per fade step; legal range >=1.
// PORTS
//  clk        in   1         48 MHz system clock (global buffer)
//  rst        in   1         asynchronous, active-high reset
//  set_valid  in   1         a duty-write request is present
//  set_ready  out  1         block can accept a write
//  set_chan   in   2         0=green, 1=red, 2=blue, 3=all channels
//  set_duty   in   PWM_BITS  target duty; 0 = off, all-ones = (2**PWM_BITS-1)/2**PWM_BITS on
//  pwm_green  out  1         to RGB0PWM
//  pwm_red    out  1         to RGB1PWM
//  pwm_blue   out  1         to RGB2PWM
//  busy       out  1         high while any channel's current duty != its target duty
// BEHAVIOUR
//  Reset values: all pwm_* = 0, busy = 0, set_ready = 0. Reset also clears the prescaler, the PWM counter, the step counter, every cur and every tgt.
//  set_ready rises on the first clk edge after rst deasserts.
//  Reset applied mid-fade or mid-handshake returns the block to the reset state immediately. No write is retained.
//  Prescaler: counts 0..PRESCALE-1. tick = 1 for one cycle when the count equals PRESCALE-1; the count then wraps to 0.
//  PWM counter pc: advances on each tick. Wraps from 2**PWM_BITS-1 to 0. wrap = tick && pc==all-ones.
//  Fade: the step counter advances on each wrap. When it reaches STEP_DIV-1 it clears and raises step.
//  On step, each channel does cur = cur+1 if cur<tgt, cur = cur-1 if cur>tgt, otherwise holds. cur never overshoots tgt.
//  Duty latch: eff = cur sampled on wrap only. The duty shown by the output therefore changes only at a period boundary, so no partial-period glitch.
//  Output: pwm_x <= (pc < eff_x), registered, giving 1 cycle of latency from pc. eff=0 means always low.
//  Handshake FSM, two states:
//    IDLE: set_ready=1. valid&&ready goes to WRITE.
//    WRITE: set_ready=0. tgt[chan] <= duty; chan=3 writes all three tgt. Returns to IDLE on the next cycle.
//  Accepted writes are spaced at least 2 cycles apart. set_chan and set_duty are sampled only in the accepting cycle.
//  A write that lands on the same cycle as step: the step uses the old tgt, and the new tgt takes effect from the next step.
//  busy = OR over channels of (cur != tgt), registered.
// CONFIGURATION
//  RGB_PWM_GAMMA_EN defined: comparison uses g = (eff*eff) >> PWM_BITS, a square-law perceptual curve.
//    Exception: eff = all-ones maps to g = all-ones. The product is full width (2*PWM_BITS); there is no truncation before the shift.
//  RGB_PWM_GAMMA_EN undefined: linear, g = eff. No multiplier is inferred.
// STRUCTURE
//  Package rgb_pwm_pkg holds:
//    CH_GREEN=2'd0, CH_RED=2'd1, CH_BLUE=2'd2, CH_ALL=2'd3
//    the FSM state encoding, ST_IDLE=1'b0 and ST_WRITE=1'b1
//  Sub-module pwm_fade_channel, instanced three times, holds one channel's tgt/cur/eff, its optional gamma, and its comparator.
//    Its inputs are pc, wrap, step and a write strobe.
//  The prescaler, PWM counter, step counter and FSM stay in rgb_pwm_fader.
// TESTING
//  Sim parameters: PWM_BITS=4, PRESCALE=2, STEP_DIV=1, linear unless a line says otherwise.
//  1. Reset: hold rst high for 5 cycles -> all pwm_*=0, busy=0, set_ready=0.
//     Release rst -> set_ready=1 on the next edge; pwm_* stay 0 indefinitely.
//  2. Write chan=0, duty=4 -> ready low for 1 cycle, then busy=1.
//     Green cur reaches 4 after 4 periods (128 clk), then busy=0. pwm_green is then high for 4 of 16 ticks.
//  3. Write chan=3, duty=15, then chan=1, duty=0 mid-ramp -> red ramps back down to 0 without overshoot.
//     Green and blue reach 15. At steady state pwm_green is low for exactly 1 tick per period.
//  4. Hold set_valid high continuously while cycling chan/duty -> writes are accepted every 2nd cycle only.
//     The last accepted write determines tgt.
//  5. Assert rst mid-ramp (cur=7, tgt=12) -> outputs go to 0 immediately. After release cur=tgt=0 and busy=0.
//  6. RGB_PWM_GAMMA_EN defined, duty=8 -> g=4, so the pulse is 4 ticks. Duty=15 -> g=15, so the pulse is 15 ticks.

Source files
------------

// File: rtl/rgb_pwm_fader_pkg.sv
// Shared channel codes and handshake FSM encoding for the RGB PWM fader.
package rgb_pwm_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    CH_GREEN = 2'd0,
    CH_RED   = 2'd1,
    CH_BLUE  = 2'd2,
    CH_ALL   = 2'd3
  } chan_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

endpackage

// File: rtl/rgb_pwm_fader_if.sv
// Duty-write valid/ready port between the control logic and the RGB PWM fader.
interface rgb_pwm_fader_if #(
  parameter int PWM_BITS = 8
);
  logic                set_valid;
  logic                set_ready;
  logic [1:0]          set_chan;
  logic [PWM_BITS-1:0] set_duty;

  modport master (output set_valid, output set_chan, output set_duty, input set_ready);
  modport slave  (input set_valid, input set_chan, input set_duty, output set_ready);
endinterface

// File: rtl/rgb_pwm_fader_channel.sv
// One fader channel: target/current/latched duty, optional square-law curve, PWM comparator.
// RGB_PWM_GAMMA_EN selects the square-law curve; the default build is linear.
module pwm_fade_channel #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] pc_i,
  input  logic                wrap_i,
  input  logic                step_i,
  input  logic                wr_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_o,
  output logic                neq_o
);

  logic [PWM_BITS-1:0] tgt_q, tgt_d;
  logic [PWM_BITS-1:0] cur_q, cur_d;
  logic [PWM_BITS-1:0] eff_q, eff_d;
  logic [PWM_BITS-1:0] g;
  logic                pwm_q, pwm_d;

  always_comb begin
    tgt_d = wr_i ? duty_i : tgt_q;
    // Step compares against the pre-write target, so a coincident write waits for the next step.
    cur_d = cur_q;
    if (step_i) begin
      if (cur_q < tgt_q)      cur_d = cur_q + PWM_BITS'(1);
      else if (cur_q > tgt_q) cur_d = cur_q - PWM_BITS'(1);
    end
    eff_d = wrap_i ? cur_q : eff_q;
  end

`ifdef RGB_PWM_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  assign sq = {{PWM_BITS{1'b0}}, eff_q} * {{PWM_BITS{1'b0}}, eff_q};
  // Full scale stays full scale so the brightest setting is not dimmed by the curve.
  assign g  = (&eff_q) ? eff_q : sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign g  = eff_q;
`endif

  assign pwm_d = (pc_i < g);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tgt_q <= '0;
      cur_q <= '0;
      eff_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      eff_q <= eff_d;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;
  assign neq_o = (cur_q != tgt_q);

endmodule

// File: rtl/rgb_pwm_fader.sv
// Three-channel PWM/fade generator driving the RGB LED hard IP PWM inputs.
// Define RGB_PWM_GAMMA_EN for a square-law brightness curve in each channel.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 188,
  parameter int STEP_DIV = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  rgb_pwm_fader_if.slave   set_if,
  output logic             pwm_green_o,
  output logic             pwm_red_o,
  output logic             pwm_blue_o,
  output logic             busy_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int STP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  logic [PRE_W-1:0]    pre_q;
  logic [PWM_BITS-1:0] pc_q;
  logic [STP_W-1:0]    stp_q;
  logic                tick, wrap, step;

  assign tick = (pre_q == PRE_W'(PRESCALE - 1));
  assign wrap = tick && (&pc_q);
  assign step = wrap && (stp_q == STP_W'(STEP_DIV - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
      pc_q  <= '0;
      stp_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
      if (tick) pc_q <= pc_q + PWM_BITS'(1);
      if (wrap) stp_q <= step ? '0 : stp_q + STP_W'(1);
    end
  end

  // Handshake FSM; ready is registered so it stays low through reset and rises one edge later.
  state_e              state_q, state_d;
  logic                rdy_q, rdy_d;
  logic                accept, wr_act;
  logic [1:0]          chan_q;
  logic [PWM_BITS-1:0] duty_q;

  assign accept = set_if.set_valid && rdy_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = (state_d == ST_IDLE);
    wr_act = (state_q == ST_WRITE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chan_q <= '0;
      duty_q <= '0;
    end else if (accept) begin
      chan_q <= set_if.set_chan;
      duty_q <= set_if.set_duty;
    end
  end

  assign set_if.set_ready = rdy_q;

  logic [NUM_CH-1:0] wr_vec, pwm_vec, neq_vec;
  logic              busy_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_vec[i] = wr_act && (chan_q == CH_ALL || chan_q == 2'(i));

    pwm_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .pc_i   (pc_q),
      .wrap_i (wrap),
      .step_i (step),
      .wr_i   (wr_vec[i]),
      .duty_i (duty_q),
      .pwm_o  (pwm_vec[i]),
      .neq_o  (neq_vec[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) busy_q <= 1'b0;
    else       busy_q <= |neq_vec;
  end

  assign pwm_green_o = pwm_vec[CH_GREEN];
  assign pwm_red_o   = pwm_vec[CH_RED];
  assign pwm_blue_o  = pwm_vec[CH_BLUE];
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader: per-period pulse widths checked against a queue of expectations.
module tb_rgb_pwm_fader;
  localparam int PB  = 4;
  localparam int PS  = 2;
  localparam int SD  = 1;
  localparam int PER = PS * (1 << PB);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pg, pr, pbl, busy;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];
  int   el;
  int   ch_t[8] = '{3, 0, 1, 2, 2, 1, 0, 3};
  int   du_t[8] = '{2, 9, 6, 11, 5, 13, 3, 14};

  rgb_pwm_fader_if #(.PWM_BITS(PB)) sif ();

  rgb_pwm_fader #(.PWM_BITS(PB), .PRESCALE(PS), .STEP_DIV(SD)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .set_if      (sif),
    .pwm_green_o (pg),
    .pwm_red_o   (pr),
    .pwm_blue_o  (pbl),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int gam(int d);
`ifdef RGB_PWM_GAMMA_EN
    if (d == 15) return 15;
    return (d * d) >> 4;
`else
    return d;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_duty(int g, int r, int b);
    exp_q.push_back(gam(g) * PS);
    exp_q.push_back(gam(r) * PS);
    exp_q.push_back(gam(b) * PS);
  endtask

  // Counts high cycles over one PWM period per channel and pops the expected widths.
  task automatic measure(string tag);
    int cg = 0, cr = 0, cb = 0;
    repeat (PER) begin
      @(negedge clk);
      cg += int'(pg); cr += int'(pr); cb += int'(pbl);
    end
    chk({tag, "_sb_depth"}, (exp_q.size() >= 3), 1);
    if (exp_q.size() >= 3) begin
      chk({tag, "_green"}, cg, exp_q.pop_front());
      chk({tag, "_red"},   cr, exp_q.pop_front());
      chk({tag, "_blue"},  cb, exp_q.pop_front());
    end
  endtask

  task automatic do_write(int c, int d);
    int n = 0;
    @(negedge clk);
    sif.set_valid = 1'b1;
    sif.set_chan  = 2'(c);
    sif.set_duty  = PB'(d);
    while (sif.set_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wr_ready_wait", (n < 20), 1);
    @(posedge clk);
    @(negedge clk);
    sif.set_valid = 1'b0;
    chk("wr_ready_low", sif.set_ready, 0);
    @(negedge clk);
    chk("wr_ready_back", sif.set_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_idle(string tag, int budget, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_idle_bound"}, (cyc < budget), 1);
  endtask

  initial begin
    sif.set_valid = 1'b0;
    sif.set_chan  = '0;
    sif.set_duty  = '0;
    rst = 1'b1;

    // 1. reset state and release
    repeat (5) @(negedge clk);
    chk("rst_green", pg, 0);
    chk("rst_red",   pr, 0);
    chk("rst_blue",  pbl, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_ready", sif.set_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_rise", sif.set_ready, 1);
    expect_duty(0, 0, 0);
    measure("idle_a");
    expect_duty(0, 0, 0);
    measure("idle_b");
    chk("idle_busy", busy, 0);

    // 2. single green write, ramp time and pulse width
    do_write(0, 4);
    chk("t2_busy", busy, 1);
    wait_idle("t2", 400, el);
    chk("t2_ramp_time", (el >= 90 && el <= 135), 1);
    repeat (PER + 4) @(negedge clk);
    expect_duty(4, 0, 0);
    measure("t2");

    // 3. all to full, then red back to zero mid-ramp
    do_write(3, 15);
    repeat (5 * PER) @(negedge clk);
    chk("t3_busy_mid", busy, 1);
    do_write(1, 0);
    wait_idle("t3", 1000, el);
    repeat (PER + 4) @(negedge clk);
    expect_duty(15, 0, 15);
    measure("t3");

    // 4. valid held high: accepted only on alternate cycles, last accepted wins
    for (int i = 0; i < 8; i++) begin
      sif.set_valid = 1'b1;
      sif.set_chan  = 2'(ch_t[i]);
      sif.set_duty  = PB'(du_t[i]);
      chk("t4_ready_pattern", sif.set_ready, ((i % 2) == 0));
      @(negedge clk);
    end
    sif.set_valid = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle("t4", 1000, el);
    repeat (PER + 4) @(negedge clk);
    expect_duty(3, 6, 5);
    measure("t4");

    // 5. reset mid-ramp, with a pending request that must not survive
    do_write(3, 0);
    wait_idle("t5_pre", 1000, el);
    do_write(3, 12);
    repeat (6 * PER + PER / 2) @(negedge clk);
    chk("t5_busy_mid", busy, 1);
    sif.set_valid = 1'b1;
    sif.set_chan  = 2'(3);
    sif.set_duty  = PB'(9);
    #1 rst = 1'b1;
    #1;
    chk("t5_rst_green", pg, 0);
    chk("t5_rst_red",   pr, 0);
    chk("t5_rst_blue",  pbl, 0);
    chk("t5_rst_busy",  busy, 0);
    chk("t5_rst_ready", sif.set_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sif.set_valid = 1'b0;
    @(negedge clk);
    chk("t5_ready_rise", sif.set_ready, 1);
    expect_duty(0, 0, 0);
    measure("t5");
    chk("t5_busy_after", busy, 0);

    // 6. mid and full-scale duty through the output curve
    do_write(0, 8);
    do_write(2, 15);
    wait_idle("t6", 1000, el);
    repeat (PER + 4) @(negedge clk);
    expect_duty(8, 0, 15);
    measure("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
